// File: rtl/bomb_squad_pkg.sv
// Shared Bomb Squad definitions: LCD display state codes and the message scheduler FSM states.
package bomb_squad_pkg;

  localparam logic [7:0] LCD_AUTH          = 8'h00;
  localparam logic [7:0] LCD_ACCESS_OK     = 8'h01;
  localparam logic [7:0] LCD_ACCESS_DENIED = 8'h02;
  localparam logic [7:0] LCD_IN_PROGRESS   = 8'h10;
  localparam logic [7:0] LCD_LVL_RES_0     = 8'h11;
  localparam logic [7:0] LCD_LVL_RES_1     = 8'h12;
  localparam logic [7:0] LCD_LVL_RES_2     = 8'h13;
  localparam logic [7:0] LCD_LVL_RES_3     = 8'h14;
  localparam logic [7:0] LCD_LVL_RES_4     = 8'h15;
  localparam logic [7:0] LCD_LVL_RES_5     = 8'h16;
  localparam logic [7:0] LCD_SUCCESS       = 8'h20;
  localparam logic [7:0] LCD_SUCCESS_ALT   = 8'h21;
  localparam logic [7:0] LCD_GAME_OVER     = 8'h30;
  localparam logic [7:0] LCD_BOMB_EXPLODED = 8'h31;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } sched_state_t;

endpackage

// File: rtl/lcd_msg_scheduler_rr_pick.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] winner_oh,
  output logic [PTR_W-1:0] winner_idx,
  output logic             valid
);

  int cand;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (!valid && req[cand]) begin
        valid           = 1'b1;
        winner_oh[cand] = 1'b1;
        winner_idx      = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Round-robin owner of the LCD controller state input with a minimum on-screen hold per message.
// Optional PREEMPT_EN: requester 0 (game over / bomb exploded) may cut short any other holder.
module lcd_msg_scheduler
  import bomb_squad_pkg::*;
#(
  parameter int          N_REQ     = 4,
  parameter int          HOLD_CYC  = 50000000,
  parameter logic [7:0]  IDLE_CODE = LCD_AUTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] code_in,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               hold_done,
  output logic [7:0]         state_out
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] w);
    return (int'(w) == N_REQ - 1) ? '0 : w + PTR_W'(1);
  endfunction

  sched_state_t      state_q, state_n;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [N_REQ-1:0]  grant_q, grant_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic [7:0]        code_q, code_n;

  logic [N_REQ-1:0]  pick_oh;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_vld;
  logic              preempt;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .valid      (pick_vld)
  );

`ifdef PREEMPT_EN
  // Current holder index; only consulted while holding, so it needs no reset.
  logic [PTR_W-1:0] holder_q;

  assign preempt = req[0] && (holder_q != '0);

  always_ff @(posedge clk) begin
    if (grant_n != '0) holder_q <= (state_q == S_HOLD) ? '0 : pick_idx;
  end
`else
  assign preempt = 1'b0;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_n  = state_q;
    rr_ptr_n = rr_ptr_q;
    cnt_n    = cnt_q;
    grant_n  = '0;
    busy_n   = busy_q;
    done_n   = 1'b0;
    code_n   = code_q;
    case (state_q)
      S_IDLE: begin
        busy_n = 1'b0;
        if (pick_vld) begin
          grant_n  = pick_oh;
          code_n   = code_in[8*int'(pick_idx) +: 8];
          busy_n   = 1'b1;
          cnt_n    = CNT_LOAD;
          rr_ptr_n = ptr_after(pick_idx);
          state_n  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (preempt) begin
          grant_n  = N_REQ'(1);
          code_n   = code_in[7:0];
          busy_n   = 1'b1;
          cnt_n    = CNT_LOAD;
          rr_ptr_n = PTR_W'(1);
        end else if (cnt_q == '0) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          cnt_n  = sat_dec(cnt_q);
          busy_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      code_q   <= IDLE_CODE;
    end else begin
      state_q  <= state_n;
      rr_ptr_q <= rr_ptr_n;
      cnt_q    <= cnt_n;
      grant_q  <= grant_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      code_q   <= code_n;
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign hold_done = done_q;
  assign state_out = code_q;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Scoreboard bench for lcd_msg_scheduler: HOLD_CYC=10 main instance plus a HOLD_CYC=1 instance.
module tb_lcd_msg_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req1;
  logic [31:0] code_in, code_in1;
  logic [3:0]  grant, grant1;
  logic        busy, busy1, hold_done, hold_done1;
  logic [7:0]  state_out, state_out1;

  always #5 clk = ~clk;

  lcd_msg_scheduler #(.N_REQ(4), .HOLD_CYC(10), .IDLE_CODE(8'h00)) dut (
    .clk(clk), .reset(reset), .req(req), .code_in(code_in),
    .grant(grant), .busy(busy), .hold_done(hold_done), .state_out(state_out)
  );

  lcd_msg_scheduler #(.N_REQ(4), .HOLD_CYC(1), .IDLE_CODE(8'h00)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .code_in(code_in1),
    .grant(grant1), .busy(busy1), .hold_done(hold_done1), .state_out(state_out1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic [7:0] code;
    logic       done;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  function automatic ev_t mk(input int c, input logic [3:0] g, input logic [7:0] code, input logic d);
    ev_t e;
    e.cyc = c; e.grant = g; e.code = code; e.done = d;
    return e;
  endfunction

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    chk8({nm, "_state_out"}, state_out, 8'h00);
    chk8({nm, "_grant"}, {4'h0, grant}, 8'h00);
    chk8({nm, "_busy"}, {7'h0, busy}, 8'h00);
    chk8({nm, "_hold_done"}, {7'h0, hold_done}, 8'h00);
  endtask

  task automatic check_ev(input string nm, input ev_t e, input int c, input logic [3:0] g,
                          input logic [7:0] so, input logic b, input logic hd);
    logic exp_busy;
    exp_busy = (e.grant != 4'h0);
    checks++;
    if (c != e.cyc || g !== e.grant || so !== e.code || hd !== e.done || b !== exp_busy) begin
      errors++;
      $display("FAIL %s: got cyc=%0d grant=%b code=%h busy=%b hold_done=%b, expected cyc=%0d grant=%b code=%h busy=%b hold_done=%b",
               nm, c, g, so, b, hd, e.cyc, e.grant, e.code, exp_busy, e.done);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (reset === 1'b1 && (grant != 4'h0 || hold_done)) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut_unexpected_event: got cyc=%0d grant=%b hold_done=%b, expected no event",
                 cyc, grant, hold_done);
      end else begin
        e = q0.pop_front();
        check_ev("dut_event", e, cyc, grant, state_out, busy, hold_done);
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (reset === 1'b1 && (grant1 != 4'h0 || hold_done1)) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_event: got cyc=%0d grant=%b hold_done=%b, expected no event",
                 cyc, grant1, hold_done1);
      end else begin
        e = q1.pop_front();
        check_ev("dut1_event", e, cyc, grant1, state_out1, busy1, hold_done1);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int c;
    reset = 1'b0; req = '0; req1 = '0; code_in = '0; code_in1 = '0;
    repeat (2) @(negedge clk);
    check_reset("reset_initial");
    reset = 1'b1;

    // Single request from requester 2
    @(negedge clk);
    c = cyc;
    code_in[23:16] = 8'h11;
    req = 4'b0100;
    q0.push_back(mk(c + 1, 4'b0100, 8'h11, 1'b0));
    q0.push_back(mk(c + 11, 4'b0000, 8'h11, 1'b1));
    @(negedge clk);
    req = '0;
    wait_until(c + 14);

    // Round robin from a fresh pointer with all requests held
    reset = 1'b0;
    @(negedge clk);
    check_reset("reset_before_rr");
    reset = 1'b1;
    code_in = {8'h30, 8'h11, 8'h20, 8'h10};
    c = cyc;
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      q0.push_back(mk(c + 1 + 11 * i, 4'(1 << (i % 4)), code_in[8 * (i % 4) +: 8], 1'b0));
      q0.push_back(mk(c + 11 + 11 * i, 4'b0000, code_in[8 * (i % 4) +: 8], 1'b1));
    end
    wait_until(c + 45);
    req = '0;
    wait_until(c + 57);

    // Reset in the middle of a hold: no hold_done, pointer back to 0
    c = cyc;
    code_in[15:8] = 8'h21;
    req = 4'b0010;
    q0.push_back(mk(c + 1, 4'b0010, 8'h21, 1'b0));
    @(negedge clk);
    req = '0;
    wait_until(c + 5);
    reset = 1'b0;
    @(negedge clk);
    check_reset("reset_mid_hold");
    reset = 1'b1;
    wait_until(c + 20);
    c = cyc;
    code_in[31:24] = 8'h31;
    req = 4'b1010;
    q0.push_back(mk(c + 1, 4'b0010, 8'h21, 1'b0));
    q0.push_back(mk(c + 11, 4'b0000, 8'h21, 1'b1));
    @(negedge clk);
    req = '0;
    wait_until(c + 13);

    // Requester 0 arrives while requester 2 holds
    c = cyc;
    code_in[23:16] = 8'h12;
    code_in[7:0] = 8'h30;
    req = 4'b0100;
    q0.push_back(mk(c + 1, 4'b0100, 8'h12, 1'b0));
    @(negedge clk);
    req = '0;
    wait_until(c + 3);
    req = 4'b0001;
`ifdef PREEMPT_EN
    q0.push_back(mk(c + 4, 4'b0001, 8'h30, 1'b0));
    q0.push_back(mk(c + 14, 4'b0000, 8'h30, 1'b1));
    wait_until(c + 4);
    req = '0;
    wait_until(c + 16);
`else
    q0.push_back(mk(c + 11, 4'b0000, 8'h12, 1'b1));
    q0.push_back(mk(c + 12, 4'b0001, 8'h30, 1'b0));
    q0.push_back(mk(c + 22, 4'b0000, 8'h30, 1'b1));
    wait_until(c + 12);
    req = '0;
    wait_until(c + 24);
`endif

    // HOLD_CYC=1 instance: held request re-granted every second cycle
    c = cyc;
    code_in1[15:8] = 8'h16;
    req1 = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      q1.push_back(mk(c + 1 + 2 * i, 4'b0010, 8'h16, 1'b0));
      q1.push_back(mk(c + 2 + 2 * i, 4'b0000, 8'h16, 1'b1));
    end
    wait_until(c + 7);
    req1 = '0;
    wait_until(c + 12);

    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d/%0d outstanding, expected 0/0", q0.size(), q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
